// File: rtl/stream_demux.sv
// stream_demux: 1-to-N valid/ready stream demultiplexer with a one-entry output slot per channel.
// Define STREAM_DEMUX_BCAST_EN to add the in_bcast broadcast input.
module stream_demux #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
`ifdef STREAM_DEMUX_BCAST_EN
  input  logic                      in_bcast,
`endif
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [7:0]                drop_cnt
);

  localparam int unsigned DATA_W = CHANNELS * WIDTH;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0]   r_data;
  logic [CHANNELS-1:0] r_valid;
  logic [CNT_W-1:0]    r_drop_cnt;

  logic                w_bcast;
  logic [CHANNELS-1:0] w_can_load;
  logic [CHANNELS-1:0] w_sel_hit;
  logic                w_sel_can_load;
  logic                w_in_range;
  logic                w_accept;
  logic [CHANNELS-1:0] w_load;
  logic                w_drop;

`ifdef STREAM_DEMUX_BCAST_EN
  assign w_bcast = in_bcast;
`else
  assign w_bcast = 1'b0;
`endif

  // A slot can take a new word when empty or when it is draining this edge.
  assign w_can_load = ~r_valid | out_ready;

  // Decode the select; an index past the last channel hits nothing.
  always_comb begin
    w_sel_hit      = '0;
    w_sel_can_load = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (32'(in_sel) == k) begin
        w_sel_hit[k]   = 1'b1;
        w_sel_can_load = w_can_load[k];
      end
    end
  end

  assign w_in_range = |w_sel_hit;

  // Combinational ready path from in_sel/out_ready; independent of in_valid.
  always_comb begin
    in_ready = 1'b1;
    if (w_bcast) begin
      in_ready = &w_can_load;
    end else if (w_in_range) begin
      in_ready = w_sel_can_load;
    end
  end

  assign w_accept = in_valid && in_ready;
  assign w_drop   = w_accept && !w_bcast && !w_in_range;

  always_comb begin
    w_load = '0;
    if (w_accept) begin
      w_load = w_bcast ? {CHANNELS{1'b1}} : w_sel_hit;
    end
  end

  // Per-channel slots: load wins over drain so valid stays high on a same-edge swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (w_load[k]) begin
          r_valid[k]               <= 1'b1;
          r_data[k*WIDTH +: WIDTH] <= in_data;
        end else if (out_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

  // Saturating count of words discarded for an out-of-range select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != CNT_MAX)) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed scenarios plus randomized traffic
// checked against an occupancy/last-word reference model.
module tb_stream_demux;

  logic        clk;
  logic        rst_n;

  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  drop_cnt;

  logic [15:0] in_data3;
  logic [1:0]  in_sel3;
  logic        in_valid3;
  logic        in_ready3;
  logic [47:0] out_data3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3;
  logic [7:0]  drop_cnt3;

`ifdef STREAM_DEMUX_BCAST_EN
  logic        in_bcast;
  logic        in_bcast3;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_drops3 = 0;

  stream_demux #(.WIDTH(16), .CHANNELS(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
`ifdef STREAM_DEMUX_BCAST_EN
    .in_bcast(in_bcast),
`endif
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .drop_cnt(drop_cnt)
  );

  stream_demux #(.WIDTH(16), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data3), .in_sel(in_sel3), .in_valid(in_valid3),
`ifdef STREAM_DEMUX_BCAST_EN
    .in_bcast(in_bcast3),
`endif
    .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .drop_cnt(drop_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    in_valid   = 1'b0;
    in_valid3  = 1'b0;
    out_ready  = '1;
    out_ready3 = '1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = '0;
    in_data3 = '0; in_sel3 = '0; in_valid3 = 1'b0; out_ready3 = '0;
`ifdef STREAM_DEMUX_BCAST_EN
    in_bcast = 1'b0; in_bcast3 = 1'b0;
`endif
    #3;
    n_vec++;
    if (out_valid !== 4'b0000) begin
      n_err++; $display("FAIL reset_valid: got %b expected %b", out_valid, 4'b0000);
    end
    n_vec++;
    if (out_data !== 64'h0) begin
      n_err++; $display("FAIL reset_data: got %h expected %h", out_data, 64'h0);
    end
    n_vec++;
    if (drop_cnt3 !== 8'd0) begin
      n_err++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt3);
    end
    for (int s = 0; s < 4; s++) begin
      in_sel  = 2'(s);
      in_sel3 = 2'(s);
      #1;
      n_vec++;
      if (in_ready !== 1'b1 || in_ready3 !== 1'b1) begin
        n_err++; $display("FAIL reset_ready sel=%0d: got %b/%b expected 1/1", s, in_ready, in_ready3);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_route();
    logic [63:0] exp_d;
    out_ready = '1;
    in_data = 16'hA5A5; in_sel = 2'd2; in_valid = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL route_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    exp_d = {16'h0, 16'hA5A5, 32'h0};
    n_vec++;
    if (out_valid !== 4'b0100) begin
      n_err++; $display("FAIL route_valid: got %b expected %b", out_valid, 4'b0100);
    end
    n_vec++;
    if (out_data !== exp_d) begin
      n_err++; $display("FAIL route_data: got %h expected %h", out_data, exp_d);
    end
    tick();
    n_vec++;
    if (out_valid !== 4'b0000 || out_data !== exp_d) begin
      n_err++; $display("FAIL route_drain_hold: got %b/%h expected 0000/%h", out_valid, out_data, exp_d);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1101;
    in_data = 16'h1111; in_sel = 2'd1; in_valid = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 4'b0010 || out_data[16 +: 16] !== 16'h1111) begin
      n_err++; $display("FAIL bp_first: got %b/%h expected 0010/1111", out_valid, out_data[16 +: 16]);
    end
    in_data = 16'h2222;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_full_ready: got %b expected 0", in_ready);
    end
    tick();
    n_vec++;
    if (out_valid !== 4'b0010 || out_data[16 +: 16] !== 16'h1111) begin
      n_err++; $display("FAIL bp_stall_hold: got %b/%h expected 0010/1111", out_valid, out_data[16 +: 16]);
    end
    out_ready = 4'b1111;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 4'b0010 || out_data[16 +: 16] !== 16'h2222) begin
      n_err++; $display("FAIL bp_swap: got %b/%h expected 0010/2222", out_valid, out_data[16 +: 16]);
    end
    tick();
    n_vec++;
    if (out_valid !== 4'b0000) begin
      n_err++; $display("FAIL bp_drain: got %b expected 0000", out_valid);
    end
  endtask

  task automatic test_independence();
    out_ready = 4'b1110;
    in_data = 16'h0007; in_sel = 2'd0; in_valid = 1'b1;
    tick();
    in_data = 16'h0003; in_sel = 2'd3;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL indep_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 4'b1001 || out_data[48 +: 16] !== 16'h0003) begin
      n_err++; $display("FAIL indep_valid: got %b/%h expected 1001/0003", out_valid, out_data[48 +: 16]);
    end
    in_data = 16'h0009; in_sel = 2'd0; in_valid = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL indep_stalled_ready: got %b expected 0", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 4'b0001 || out_data[0 +: 16] !== 16'h0007) begin
      n_err++; $display("FAIL indep_hold: got %b/%h expected 0001/0007", out_valid, out_data[0 +: 16]);
    end
    flush();
  endtask

  task automatic test_drops();
    out_ready3 = '0;
    in_sel3 = 2'd3; in_valid3 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data3 = 16'(i + 1);
      #1;
      n_vec++;
      if (in_ready3 !== 1'b1) begin
        n_err++; $display("FAIL drop_ready i=%0d: got %b expected 1", i, in_ready3);
      end
      tick();
      if (i == 9 || i == 253 || i == 254 || i == 255) begin
        n_vec++;
        if (32'(drop_cnt3) !== ((i + 1 > 255) ? 255 : i + 1)) begin
          n_err++; $display("FAIL drop_cnt i=%0d: got %0d expected %0d", i, drop_cnt3, (i + 1 > 255) ? 255 : i + 1);
        end
      end
    end
    in_valid3 = 1'b0;
    n_vec++;
    if (drop_cnt3 !== 8'd255) begin
      n_err++; $display("FAIL drop_sat: got %0d expected 255", drop_cnt3);
    end
    n_vec++;
    if (out_valid3 !== 3'b000 || out_data3 !== 48'h0) begin
      n_err++; $display("FAIL drop_no_load: got %b/%h expected 000/0", out_valid3, out_data3);
    end
  endtask

  task automatic test_async_reset();
    out_ready = '0;
    for (int k = 0; k < 4; k++) begin
      in_data = 16'h1000 + 16'(k); in_sel = 2'(k); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 4'b1111) begin
      n_err++; $display("FAIL arst_full: got %b expected 1111", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 4'b0000 || out_data !== 64'h0) begin
      n_err++; $display("FAIL arst_clear: got %b/%h expected 0000/0", out_valid, out_data);
    end
    n_vec++;
    if (drop_cnt3 !== 8'd0) begin
      n_err++; $display("FAIL arst_drop: got %0d expected 0", drop_cnt3);
    end
    #1;
    rst_n = 1'b1;
    in_data = 16'h00C1; in_sel = 2'd1; in_valid = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL arst_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 4'b0010 || out_data !== {32'h0, 16'h00C1, 16'h0}) begin
      n_err++; $display("FAIL arst_first: got %b/%h expected 0010/%h", out_valid, out_data, {32'h0, 16'h00C1, 16'h0});
    end
    flush();
  endtask

  // Reference: each channel is a depth-1 queue (occupancy count) plus the last word written.
  task automatic test_random();
    int          occ [4];
    logic [15:0] last [4];
    logic [15:0] d;
    logic [1:0]  s, s3;
    logic        v, v3, exp_rdy;
    logic [3:0]  r, exp_v;
    logic [63:0] exp_d;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    exp_drops3 = 0;
    for (int k = 0; k < 4; k++) begin
      occ[k] = 0; last[k] = '0;
    end
    out_ready3 = '1;
    for (int c = 0; c < 400; c++) begin
      d  = 16'($urandom);
      s  = 2'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      r  = 4'($urandom | $urandom);
      s3 = 2'($urandom);
      v3 = ($urandom_range(0, 3) != 0);
      in_data = d; in_sel = s; in_valid = v; out_ready = r;
      in_data3 = d; in_sel3 = s3; in_valid3 = v3;
      exp_rdy = (occ[s] == 0) || r[s];
      #1;
      n_vec++;
      if (in_ready !== exp_rdy) begin
        n_err++; $display("FAIL rnd_ready c=%0d: got %b expected %b", c, in_ready, exp_rdy);
      end
      tick();
      for (int k = 0; k < 4; k++) begin
        if (occ[k] > 0 && r[k]) occ[k] = occ[k] - 1;
      end
      if (v && exp_rdy) begin
        occ[s] = occ[s] + 1;
        last[s] = d;
      end
      if (v3 && s3 == 2'd3) exp_drops3++;
      for (int k = 0; k < 4; k++) begin
        exp_v[k] = (occ[k] != 0);
        exp_d[k*16 +: 16] = last[k];
      end
      n_vec++;
      if (out_valid !== exp_v || out_data !== exp_d) begin
        n_err++; $display("FAIL rnd_out c=%0d: got %b/%h expected %b/%h", c, out_valid, out_data, exp_v, exp_d);
      end
      n_vec++;
      if (32'(drop_cnt3) !== ((exp_drops3 > 255) ? 255 : exp_drops3)) begin
        n_err++; $display("FAIL rnd_drop c=%0d: got %0d expected %0d", c, drop_cnt3, exp_drops3);
      end
    end
    flush();
  endtask

`ifdef STREAM_DEMUX_BCAST_EN
  task automatic test_bcast();
    out_ready = 4'b1011;
    in_data = 16'h0022; in_sel = 2'd2; in_valid = 1'b1; in_bcast = 1'b0;
    tick();
    in_data = 16'hBEEF; in_bcast = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL bcast_blocked: got %b expected 0", in_ready);
    end
    tick();
    n_vec++;
    if (out_valid !== 4'b0100 || out_data[32 +: 16] !== 16'h0022) begin
      n_err++; $display("FAIL bcast_stall: got %b/%h expected 0100/0022", out_valid, out_data[32 +: 16]);
    end
    out_ready = 4'b1111;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL bcast_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0; in_bcast = 1'b0;
    n_vec++;
    if (out_valid !== 4'b1111 || out_data !== {4{16'hBEEF}}) begin
      n_err++; $display("FAIL bcast_all: got %b/%h expected 1111/%h", out_valid, out_data, {4{16'hBEEF}});
    end
    in_data3 = 16'h5A5A; in_sel3 = 2'd3; in_valid3 = 1'b1; in_bcast3 = 1'b1;
    tick();
    in_valid3 = 1'b0; in_bcast3 = 1'b0;
    n_vec++;
    if (out_valid3 !== 3'b111 || out_data3 !== {3{16'h5A5A}}) begin
      n_err++; $display("FAIL bcast3_all: got %b/%h expected 111/%h", out_valid3, out_data3, {3{16'h5A5A}});
    end
    n_vec++;
    if (32'(drop_cnt3) !== ((exp_drops3 > 255) ? 255 : exp_drops3)) begin
      n_err++; $display("FAIL bcast3_drop: got %0d expected %0d", drop_cnt3, exp_drops3);
    end
    flush();
  endtask
`endif

  initial begin
    test_reset();
    test_route();
    test_backpressure();
    test_independence();
    test_drops();
    test_async_reset();
    test_random();
`ifdef STREAM_DEMUX_BCAST_EN
    test_bcast();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
